taxi_eth_phy_10g_rx_lock_mlane: RTL and testbench
=================================================

// Module: taxi_eth_phy_10g_rx_lock_mlane
//
// PURPOSE
// Multi-lane 64b/66b receive block-lock, bitslip and BER monitor for the 10G/25G/40G PCS receive path.
// Sits between N SERDES lane gearboxes and the descrambler/decoder. Each lane is locked independently per
// IEEE 802.3 cl.49/82 (64-header window, 16-invalid threshold). The block reports per-lane and aggregate status.
// Generalises the single-lane lock/BER logic: lane count, pulse shapes, timeouts and counter widths are parameters.
//
// PARAMETERS
// LANES               1        number of independent 66b lanes (1..8)
// HDR_W               2        sync header width per lane
// BITSLIP_HIGH_CYCLES 0        bitslip pulse length in cycles (0 treated as 1)
// BITSLIP_LOW_CYCLES  7        post-slip hold-off in cycles; headers ignored during hold-off
// COUNT_125US         19531    rx_clk cycles per BER window (125 us at 156.25 MHz); must be >= 2
// ERR_CNT_W           7        width of per-lane saturating error counter
// RESET_TIMEOUT       1000000  cycles without lock before a lane requests SERDES reset; 0 disables
//
// PORTS
// rx_clk               in   1               receive clock; all logic in this domain
// rx_rst               in   1               synchronous, active-high reset
// serdes_rx_hdr        in   LANES*HDR_W     sync headers, lane l at [l*HDR_W +: HDR_W]
// serdes_rx_hdr_valid  in   LANES           header qualifier per lane
// cfg_err_clear        in   1               pulse: clear all rx_error_count fields
// serdes_rx_bitslip    out  LANES           bitslip request to lane gearbox
// serdes_rx_reset_req  out  LANES           1-cycle SERDES reset request per lane
// rx_block_lock        out  LANES           lane block lock
// rx_high_ber          out  LANES           lane high-BER flag
// rx_error_count       out  LANES*ERR_CNT_W invalid-header count while locked, saturating
// rx_all_lock          out  1               AND of rx_block_lock
// rx_status            out  1               rx_all_lock & ~|rx_high_ber
//
// BEHAVIOUR
// - Reset: all outputs 0, all counters 0, every lane FSM in HUNT. Reset mid-slip aborts pulse/hold-off.
// - Header valid: hdr == 2'b01 or 2'b10; 2'b00/2'b11 invalid. Only cycles with hdr_valid[l]=1 count.
// - Lane FSM states: HUNT, LOCKED, SLIP, HOLD. sh_cnt (7b) and sh_invld_cnt (5b) per lane.
// - HUNT: valid hdr -> sh_cnt++; invalid hdr -> SLIP, counters cleared. sh_cnt reaching 64 -> LOCKED,
//   rx_block_lock=1 on the cycle after the 64th valid header is sampled; counters cleared.
// - LOCKED: each hdr -> sh_cnt++; invalid -> sh_invld_cnt++. sh_invld_cnt reaching 16 -> lock=0 next cycle, SLIP.
//   sh_cnt reaching 64 with sh_invld_cnt<16 -> both cleared, stay LOCKED (16th invalid on 64th hdr: unlock wins).
// - SLIP: serdes_rx_bitslip[l]=1 for max(BITSLIP_HIGH_CYCLES,1) cycles, then HOLD.
// - HOLD: BITSLIP_LOW_CYCLES cycles (0 -> skip), headers ignored, then HUNT.
// - Error count: +1 per invalid hdr sampled in LOCKED; saturates at 2^ERR_CNT_W-1; cfg_err_clear wins over increment.
// - BER: one shared window timer 0..COUNT_125US-1, free-running from reset. Per-lane ber_cnt (5b, saturates at 16)
//   increments on invalid hdr in LOCKED. ber_cnt reaching 16 -> rx_high_ber=1 next cycle.
//   At window end: rx_high_ber <= (ber_cnt incl. this cycle >= 16); ber_cnt reloads to 0.
//   Invalid hdr on the window-end cycle counts in the closing window.
//   Lane leaving LOCKED clears ber_cnt; rx_high_ber holds until next window end.
// - Reset request: per-lane counter runs while rx_block_lock[l]=0; at RESET_TIMEOUT pulse reset_req[l] 1 cycle,
//   counter restarts. Any lock clears the counter.
// - Lanes fully independent; rx_all_lock/rx_status registered, one cycle after per-lane flags.
//
// TESTING
// - Lane0 64 valid hdrs (01/10 alternating) -> rx_block_lock[0]=1 cycle after 64th; other lanes stay 0.
// - HUNT, 1 hdr=11, defaults -> bitslip 1 cycle, next 7 hdrs ignored, HUNT resumes; LOW=3,HIGH=2 -> 2 high/3 hold.
// - LOCKED, 15 invalid in 64 -> stays locked, error_count=15; 16 invalid in 64 -> unlock + bitslip, count=16.
// - COUNT_125US=100, 16 invalid in window -> high_ber=1; next window clean -> high_ber=0 at window end.
// - ERR_CNT_W=3, 9 invalid while locked -> count saturates 7; cfg_err_clear with invalid hdr same cycle -> 0.
// - RESET_TIMEOUT=50, no valid hdrs -> reset_req pulse at cycles 50,100; rx_rst during SLIP -> all outputs 0.

Source files
------------

// File: rtl/taxi_eth_phy_10g_rx_lock_mlane_if.sv
// Bundle between the lane gearboxes, the lock/BER block and its status consumers.
// The block itself takes the slave view; whatever feeds headers takes the master view.
interface taxi_eth_phy_10g_rx_lock_mlane_if #(
  parameter int LANES     = 1,
  parameter int HDR_W     = 2,
  parameter int ERR_CNT_W = 7
);
  logic [LANES*HDR_W-1:0]     serdes_rx_hdr;
  logic [LANES-1:0]           serdes_rx_hdr_valid;
  logic                       cfg_err_clear;
  logic [LANES-1:0]           serdes_rx_bitslip;
  logic [LANES-1:0]           serdes_rx_reset_req;
  logic [LANES-1:0]           rx_block_lock;
  logic [LANES-1:0]           rx_high_ber;
  logic [LANES*ERR_CNT_W-1:0] rx_error_count;
  logic                       rx_all_lock;
  logic                       rx_status;

  modport master (
    output serdes_rx_hdr, serdes_rx_hdr_valid, cfg_err_clear,
    input  serdes_rx_bitslip, serdes_rx_reset_req, rx_block_lock, rx_high_ber,
           rx_error_count, rx_all_lock, rx_status
  );

  modport slave (
    input  serdes_rx_hdr, serdes_rx_hdr_valid, cfg_err_clear,
    output serdes_rx_bitslip, serdes_rx_reset_req, rx_block_lock, rx_high_ber,
           rx_error_count, rx_all_lock, rx_status
  );
endinterface

// File: rtl/taxi_eth_phy_10g_rx_lock_mlane.sv
// Multi-lane 64b/66b block lock, bitslip, BER monitor and SERDES reset watchdog.
// Each lane runs its own HUNT/LOCKED/SLIP/HOLD machine; the BER window timer is shared.
module taxi_eth_phy_10g_rx_lock_mlane #(
  parameter int LANES               = 1,
  parameter int HDR_W               = 2,
  parameter int BITSLIP_HIGH_CYCLES = 0,
  parameter int BITSLIP_LOW_CYCLES  = 7,
  parameter int COUNT_125US         = 19531,
  parameter int ERR_CNT_W           = 7,
  parameter int RESET_TIMEOUT       = 1000000
) (
  input logic                             rx_clk,
  input logic                             rx_rst,
  taxi_eth_phy_10g_rx_lock_mlane_if.slave bus
);

  localparam int HIGH_CYC = (BITSLIP_HIGH_CYCLES > 0) ? BITSLIP_HIGH_CYCLES : 1;
  localparam int SLIP_MAX = (HIGH_CYC > BITSLIP_LOW_CYCLES) ? HIGH_CYC : BITSLIP_LOW_CYCLES;
  localparam int SLIP_W   = $clog2(SLIP_MAX + 1);
  localparam int WIN_W    = $clog2(COUNT_125US);
  localparam int RST_W    = (RESET_TIMEOUT > 1) ? $clog2(RESET_TIMEOUT) : 1;

  localparam logic [SLIP_W-1:0]    HIGH_LOAD = SLIP_W'(HIGH_CYC - 1);
  localparam logic [SLIP_W-1:0]    LOW_LOAD  = SLIP_W'(BITSLIP_LOW_CYCLES - 1);
  localparam logic [WIN_W-1:0]     WIN_LAST  = WIN_W'(COUNT_125US - 1);
  localparam logic [RST_W-1:0]     RST_LAST  = RST_W'(RESET_TIMEOUT - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX   = '1;
  localparam logic [HDR_W-1:0]     SYNC_DATA = HDR_W'(1);
  localparam logic [HDR_W-1:0]     SYNC_CTRL = HDR_W'(2);

  typedef enum logic [1:0] {ST_HUNT, ST_LOCKED, ST_SLIP, ST_HOLD} lane_state_e;

  lane_state_e          state        [LANES];
  logic [6:0]           sh_cnt       [LANES];
  logic [4:0]           sh_invld_cnt [LANES];
  logic [SLIP_W-1:0]    slip_cnt     [LANES];
  logic [4:0]           ber_cnt      [LANES];
  logic [4:0]           ber_next     [LANES];
  logic [ERR_CNT_W-1:0] err_cnt      [LANES];
  logic [RST_W-1:0]     rst_cnt      [LANES];

  logic [LANES-1:0] bitslip, block_lock, high_ber, reset_req;
  logic [LANES-1:0] hdr_bad, ber_inc;
  logic [WIN_W-1:0] win_cnt;
  logic             win_end, all_lock, status;

  // NOTE: every signal driven here is assigned on every pass, so no latches are inferred.
  always_comb begin
    win_end = (win_cnt == WIN_LAST);
    for (int l = 0; l < LANES; l++) begin
      hdr_bad[l]  = bus.serdes_rx_hdr_valid[l] &&
                    (bus.serdes_rx_hdr[l*HDR_W +: HDR_W] != SYNC_DATA) &&
                    (bus.serdes_rx_hdr[l*HDR_W +: HDR_W] != SYNC_CTRL);
      ber_inc[l]  = hdr_bad[l] && (state[l] == ST_LOCKED);
      ber_next[l] = (ber_cnt[l] == 5'd16) ? 5'd16 : ber_cnt[l] + {4'd0, ber_inc[l]};
    end
  end

  // NOTE: all state uses non-blocking updates so every lane reads pre-edge values.
  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      win_cnt    <= '0;
      all_lock   <= 1'b0;
      status     <= 1'b0;
      bitslip    <= '0;
      block_lock <= '0;
      high_ber   <= '0;
      reset_req  <= '0;
      // NOTE: the per-lane arrays are plain flops, not RAM, so they are reset like any register.
      for (int l = 0; l < LANES; l++) begin
        state[l]        <= ST_HUNT;
        sh_cnt[l]       <= '0;
        sh_invld_cnt[l] <= '0;
        slip_cnt[l]     <= '0;
        ber_cnt[l]      <= '0;
        err_cnt[l]      <= '0;
        rst_cnt[l]      <= '0;
      end
    end else begin
      win_cnt  <= win_end ? '0 : win_cnt + 1'b1;
      all_lock <= &block_lock;
      status   <= (&block_lock) && !(|high_ber);

      for (int l = 0; l < LANES; l++) begin
        case (state[l])
          ST_HUNT: if (bus.serdes_rx_hdr_valid[l]) begin
            if (hdr_bad[l]) begin
              state[l]        <= ST_SLIP;
              bitslip[l]      <= 1'b1;
              slip_cnt[l]     <= HIGH_LOAD;
              sh_cnt[l]       <= '0;
              sh_invld_cnt[l] <= '0;
            end else if (sh_cnt[l] == 7'd63) begin
              state[l]        <= ST_LOCKED;
              block_lock[l]   <= 1'b1;
              sh_cnt[l]       <= '0;
              sh_invld_cnt[l] <= '0;
            end else begin
              sh_cnt[l] <= sh_cnt[l] + 7'd1;
            end
          end
          // The 16th invalid header unlocks even when it also closes the 64-header window.
          ST_LOCKED: if (bus.serdes_rx_hdr_valid[l]) begin
            if (hdr_bad[l] && sh_invld_cnt[l] == 5'd15) begin
              state[l]        <= ST_SLIP;
              block_lock[l]   <= 1'b0;
              bitslip[l]      <= 1'b1;
              slip_cnt[l]     <= HIGH_LOAD;
              sh_cnt[l]       <= '0;
              sh_invld_cnt[l] <= '0;
            end else if (sh_cnt[l] == 7'd63) begin
              sh_cnt[l]       <= '0;
              sh_invld_cnt[l] <= '0;
            end else begin
              sh_cnt[l]       <= sh_cnt[l] + 7'd1;
              sh_invld_cnt[l] <= sh_invld_cnt[l] + {4'd0, hdr_bad[l]};
            end
          end
          ST_SLIP: begin
            if (slip_cnt[l] == '0) begin
              bitslip[l] <= 1'b0;
              if (BITSLIP_LOW_CYCLES == 0) begin
                state[l] <= ST_HUNT;
              end else begin
                state[l]    <= ST_HOLD;
                slip_cnt[l] <= LOW_LOAD;
              end
            end else begin
              slip_cnt[l] <= slip_cnt[l] - 1'b1;
            end
          end
          default: begin
            if (slip_cnt[l] == '0) state[l] <= ST_HUNT;
            else                   slip_cnt[l] <= slip_cnt[l] - 1'b1;
          end
        endcase

        if (bus.cfg_err_clear)                      err_cnt[l] <= '0;
        else if (ber_inc[l] && err_cnt[l] != ERR_MAX) err_cnt[l] <= err_cnt[l] + 1'b1;

        // High-BER is re-evaluated at each window end and otherwise only sets.
        if (win_end) begin
          high_ber[l] <= (ber_next[l] >= 5'd16);
          ber_cnt[l]  <= '0;
        end else begin
          if (ber_next[l] == 5'd16) high_ber[l] <= 1'b1;
          ber_cnt[l] <= (ber_inc[l] && sh_invld_cnt[l] == 5'd15) ? 5'd0 : ber_next[l];
        end

        if (RESET_TIMEOUT == 0 || block_lock[l]) begin
          rst_cnt[l]   <= '0;
          reset_req[l] <= 1'b0;
        end else if (rst_cnt[l] == RST_LAST) begin
          rst_cnt[l]   <= '0;
          reset_req[l] <= 1'b1;
        end else begin
          rst_cnt[l]   <= rst_cnt[l] + 1'b1;
          reset_req[l] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    bus.serdes_rx_bitslip   = bitslip;
    bus.serdes_rx_reset_req = reset_req;
    bus.rx_block_lock       = block_lock;
    bus.rx_high_ber         = high_ber;
    bus.rx_all_lock         = all_lock;
    bus.rx_status           = status;
    bus.rx_error_count      = '0;
    for (int l = 0; l < LANES; l++) begin
      bus.rx_error_count[l*ERR_CNT_W +: ERR_CNT_W] = err_cnt[l];
    end
  end

endmodule

// File: tb/tb_taxi_eth_phy_10g_rx_lock_mlane.sv
// Directed bench: dut_a uses default timing with two lanes, dut_b uses short
// slip/BER/timeout parameters so window and watchdog boundaries are reachable.
module tb_taxi_eth_phy_10g_rx_lock_mlane;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_checks = 0;
  int   n_errors = 0;
  int   eb = 0;
  int   rr_cnt = 0;
  int   hits;

  always #5 clk = ~clk;

  taxi_eth_phy_10g_rx_lock_mlane_if #(.LANES(2), .HDR_W(2), .ERR_CNT_W(7)) if_a ();
  taxi_eth_phy_10g_rx_lock_mlane_if #(.LANES(1), .HDR_W(2), .ERR_CNT_W(3)) if_b ();

  taxi_eth_phy_10g_rx_lock_mlane #(
    .LANES(2)
  ) dut_a (
    .rx_clk (clk),
    .rx_rst (rst_a),
    .bus    (if_a)
  );

  taxi_eth_phy_10g_rx_lock_mlane #(
    .LANES               (1),
    .HDR_W               (2),
    .BITSLIP_HIGH_CYCLES (2),
    .BITSLIP_LOW_CYCLES  (3),
    .COUNT_125US         (100),
    .ERR_CNT_W           (3),
    .RESET_TIMEOUT       (50)
  ) dut_b (
    .rx_clk (clk),
    .rx_rst (rst_b),
    .bus    (if_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] good(input int i);
    return i[0] ? 2'b10 : 2'b01;
  endfunction

  // Lane 1 of dut_a always sees an invalid header with its qualifier low.
  task automatic a_send(input logic [1:0] h0, input logic v0, input logic clr);
    if_a.serdes_rx_hdr       = {2'b11, h0};
    if_a.serdes_rx_hdr_valid = {1'b0, v0};
    if_a.cfg_err_clear       = clr;
    @(negedge clk);
  endtask

  task automatic b_send(input logic [1:0] h, input logic v, input logic clr);
    if_b.serdes_rx_hdr       = h;
    if_b.serdes_rx_hdr_valid = v;
    if_b.cfg_err_clear       = clr;
    @(negedge clk);
    eb++;
    if (if_b.serdes_rx_reset_req) rr_cnt++;
  endtask

  initial begin
    logic       bad;
    logic       clr;

    rst_a = 1'b1;
    rst_b = 1'b1;
    if_a.serdes_rx_hdr = '0; if_a.serdes_rx_hdr_valid = '0; if_a.cfg_err_clear = 1'b0;
    if_b.serdes_rx_hdr = '0; if_b.serdes_rx_hdr_valid = '0; if_b.cfg_err_clear = 1'b0;
    repeat (3) @(negedge clk);

    check("a_rst_lock",    if_a.rx_block_lock, 0);
    check("a_rst_slip",    if_a.serdes_rx_bitslip, 0);
    check("a_rst_err",     if_a.rx_error_count, 0);
    check("a_rst_ber",     if_a.rx_high_ber, 0);
    check("a_rst_all",     if_a.rx_all_lock, 0);
    check("a_rst_status",  if_a.rx_status, 0);
    check("a_rst_rr",      if_a.serdes_rx_reset_req, 0);
    rst_a = 1'b0;

    // HUNT slip with default pulse shape; partial sh_cnt must be discarded.
    for (int i = 0; i < 5; i++) a_send(good(i), 1'b1, 1'b0);
    a_send(2'b11, 1'b1, 1'b0);
    check("a_hunt_slip", if_a.serdes_rx_bitslip, 2'b01);
    a_send(2'b11, 1'b1, 1'b0);
    check("a_slip_1cyc", if_a.serdes_rx_bitslip, 2'b00);
    hits = 0;
    repeat (7) begin
      a_send(2'b11, 1'b1, 1'b0);
      if (if_a.serdes_rx_bitslip != 2'b00) hits++;
    end
    check("a_hold_ignore", hits, 0);

    for (int i = 0; i < 64; i++) begin
      a_send(good(i), 1'b1, 1'b0);
      if (i == 62) check("a_lock_63", if_a.rx_block_lock, 2'b00);
    end
    check("a_lock_64", if_a.rx_block_lock, 2'b01);

    // First locked window: 15 invalid stays locked.
    for (int i = 0; i < 64; i++)
      a_send((i < 15) ? (i[0] ? 2'b00 : 2'b11) : good(i), 1'b1, 1'b0);
    check("a_15inv_lock", if_a.rx_block_lock, 2'b01);
    check("a_err15",      if_a.rx_error_count[6:0], 15);
    check("a_no_slip",    if_a.serdes_rx_bitslip, 2'b00);
    check("a_ber_15",     if_a.rx_high_ber, 2'b00);
    check("a_all_lane1",  if_a.rx_all_lock, 0);

    a_send(2'b11, 1'b0, 1'b1);
    check("a_err_clear", if_a.rx_error_count[6:0], 0);

    // Second window: 16th invalid unlocks; 16th cumulative invalid raises BER.
    for (int i = 0; i < 16; i++) begin
      a_send(2'b00, 1'b1, 1'b0);
      if (i == 0)  check("a_ber_16", if_a.rx_high_ber, 2'b01);
      if (i == 14) check("a_15_of_16", if_a.rx_block_lock, 2'b01);
    end
    check("a_unlock",      if_a.rx_block_lock, 2'b00);
    check("a_unlock_slip", if_a.serdes_rx_bitslip, 2'b01);
    check("a_err16",       if_a.rx_error_count[6:0], 16);
    a_send(2'b11, 1'b1, 1'b0);
    check("a_slip_pulse", if_a.serdes_rx_bitslip, 2'b00);
    hits = 0;
    repeat (7) begin
      a_send(2'b11, 1'b1, 1'b0);
      if (if_a.serdes_rx_bitslip != 2'b00) hits++;
    end
    check("a_hold2_ignore", hits, 0);
    check("a_err_frozen",   if_a.rx_error_count[6:0], 16);
    check("a_ber_hold",     if_a.rx_high_ber, 2'b01);
    check("a_lane1_err",    if_a.rx_error_count[13:7], 0);

    // dut_b: reset watchdog while no headers arrive.
    rst_b = 1'b0;
    for (int i = 0; i < 100; i++) begin
      b_send(2'b00, 1'b0, 1'b0);
      if (eb == 50 || eb == 100) check($sformatf("b_rr_%0d", eb), if_b.serdes_rx_reset_req, 1);
    end
    check("b_rr_count_100", rr_cnt, 2);

    // HUNT slip with 2-cycle pulse and 3-cycle hold-off.
    b_send(2'b11, 1'b1, 1'b0);
    check("b_slip_hi1", if_b.serdes_rx_bitslip, 1);
    b_send(2'b11, 1'b1, 1'b0);
    check("b_slip_hi2", if_b.serdes_rx_bitslip, 1);
    b_send(2'b11, 1'b1, 1'b0);
    check("b_slip_lo", if_b.serdes_rx_bitslip, 0);
    hits = 0;
    repeat (3) begin
      b_send(2'b11, 1'b1, 1'b0);
      if (if_b.serdes_rx_bitslip) hits++;
    end
    check("b_hold_ignore", hits, 0);

    for (int i = 0; i < 64; i++) begin
      b_send(good(i), 1'b1, 1'b0);
      if (eb == 150) check("b_rr_150", if_b.serdes_rx_reset_req, 1);
      if (i == 62)   check("b_lock_63", if_b.rx_block_lock, 0);
    end
    check("b_lock_64",  if_b.rx_block_lock, 1);
    check("b_all_lag",  if_b.rx_all_lock, 0);
    b_send(good(0), 1'b1, 1'b0);
    check("b_all_lock", if_b.rx_all_lock, 1);
    check("b_status",   if_b.rx_status, 1);

    // Error saturation, BER windows and clear-vs-increment, edges 172..416.
    while (eb < 416) begin
      bad = ((eb + 1 >= 201 && eb + 1 <= 209) || (eb + 1 >= 235 && eb + 1 <= 242) ||
             (eb + 1 >= 401 && eb + 1 <= 416));
      clr = (eb + 1 == 242);
      b_send(bad ? 2'b11 : good(eb), 1'b1, clr);
      case (eb)
        206: check("b_err_6",        if_b.rx_error_count, 6);
        209: begin
          check("b_err_sat",         if_b.rx_error_count, 7);
          check("b_lock_9inv",       if_b.rx_block_lock, 1);
        end
        240: check("b_ber_15",       if_b.rx_high_ber, 0);
        241: check("b_ber_set",      if_b.rx_high_ber, 1);
        242: begin
          check("b_err_clr_wins",    if_b.rx_error_count, 0);
          check("b_status_ber",      if_b.rx_status, 0);
        end
        300: check("b_ber_win_hold", if_b.rx_high_ber, 1);
        399: check("b_ber_pre_end",  if_b.rx_high_ber, 1);
        400: check("b_ber_clear",    if_b.rx_high_ber, 0);
        401: check("b_status_back",  if_b.rx_status, 1);
        415: check("b_lock_15inv",   if_b.rx_block_lock, 1);
        default: ;
      endcase
    end
    check("b_unlock",      if_b.rx_block_lock, 0);
    check("b_unlock_slip", if_b.serdes_rx_bitslip, 1);
    check("b_ber_again",   if_b.rx_high_ber, 1);
    check("b_rr_locked",   rr_cnt, 3);

    // Reset in the middle of the 2-cycle bitslip pulse.
    rst_b = 1'b1;
    b_send(2'b11, 1'b1, 1'b0);
    check("b_rst_slip",   if_b.serdes_rx_bitslip, 0);
    check("b_rst_lock",   if_b.rx_block_lock, 0);
    check("b_rst_ber",    if_b.rx_high_ber, 0);
    check("b_rst_err",    if_b.rx_error_count, 0);
    check("b_rst_all",    if_b.rx_all_lock, 0);
    check("b_rst_status", if_b.rx_status, 0);
    check("b_rst_rr",     if_b.serdes_rx_reset_req, 0);
    rst_b = 1'b0;
    b_send(good(0), 1'b1, 1'b0);
    check("b_slip_aborted", if_b.serdes_rx_bitslip, 0);
    check("b_post_rst_lock", if_b.rx_block_lock, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
